// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared N64 controller encodings, command codes and slot patterns
package n64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } tx_state_e;

  localparam int SLOT_W = 2;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [2:0] RESP_LEN_INFO   = 3'd3;
  localparam logic [2:0] RESP_LEN_STATUS = 3'd4;

  // Number of leading low slots (out of 4) for each symbol
  localparam logic [SLOT_W-1:0] LOW_SLOTS_ONE  = 2'd1;
  localparam logic [SLOT_W-1:0] LOW_SLOTS_ZERO = 2'd3;
  localparam logic [SLOT_W-1:0] LOW_SLOTS_STOP = 2'd2;

  function automatic logic [5:0] frame_bits(input logic [2:0] num_bytes);
    logic [2:0] n;
    n = (num_bytes > 3'd4) ? 3'd4 : num_bytes;
    return {n, 3'b000};
  endfunction

endpackage

// File: rtl/n64_response_tx_if.sv
// rtl/n64_response_tx_if.sv - request/status bundle between controller logic and the response transmitter
interface n64_response_tx_if;
  logic        start;
  logic [2:0]  num_bytes;
  logic [31:0] payload;
  logic        data_drive_low;
  logic        busy;
  logic        done;

  modport master (
    output start, num_bytes, payload,
    input  data_drive_low, busy, done
  );

  modport slave (
    input  start, num_bytes, payload,
    output data_drive_low, busy, done
  );
endinterface

// File: rtl/n64_slot_timer.sv
// rtl/n64_slot_timer.sv - divides sample_clk into 1 us slots and groups four slots into one bit time
module n64_slot_timer
  import n64_pkg::*;
#(
  parameter int US_TICKS = 4
) (
  input  logic              sample_clk,
  input  logic              reset,
  input  logic              run,
  output logic [SLOT_W-1:0] slot,
  output logic              bit_end
);

  localparam int TICK_W = $clog2(US_TICKS);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(US_TICKS - 1);

  logic [TICK_W-1:0] tick;
  logic              tick_wrap;

  assign tick_wrap = (tick == TICK_MAX);
  assign bit_end   = run && tick_wrap && (slot == '1);

  // Held at zero while idle so every bit starts on a clean slot boundary
  always_ff @(posedge sample_clk) begin
    if (reset || !run) begin
      tick <= '0;
      slot <= '0;
    end else if (tick_wrap) begin
      tick <= '0;
      slot <= slot + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/n64_response_tx.sv
// rtl/n64_response_tx.sv - serializes a 1-4 byte controller response plus stop bit onto the N64 data line
module n64_response_tx
  import n64_pkg::*;
#(
  parameter int US_TICKS = 4
) (
  input  logic             sample_clk,
  input  logic             reset,
  n64_response_tx_if.slave bus
);

  tx_state_e         state;
  logic [31:0]       shift_reg;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_total;
  logic              stop_end;
  logic              drive_low_q;
  logic              busy_q;
  logic              done_q;
  logic [SLOT_W-1:0] slot;
  logic              bit_end;
  logic [SLOT_W-1:0] low_slots;

  n64_slot_timer #(.US_TICKS(US_TICKS)) u_slot_timer (
    .sample_clk (sample_clk),
    .reset      (reset),
    .run        (state != ST_IDLE),
    .slot       (slot),
    .bit_end    (bit_end)
  );

  always_comb begin
    low_slots = '0;
    case (state)
      ST_DATA: low_slots = shift_reg[31] ? LOW_SLOTS_ONE : LOW_SLOTS_ZERO;
      ST_STOP: low_slots = LOW_SLOTS_STOP;
      default: low_slots = '0;
    endcase
  end

  // Outputs trail the state by one cycle; done is delayed to land on the first non-busy cycle
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      bit_total   <= '0;
      stop_end    <= 1'b0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      drive_low_q <= (slot < low_slots);
      busy_q      <= (state != ST_IDLE);
      done_q      <= stop_end;
      stop_end    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !busy_q && (bus.num_bytes != 3'd0)) begin
            shift_reg <= bus.payload;
            bit_total <= frame_bits(bus.num_bytes);
            bit_cnt   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_reg <= {shift_reg[30:0], 1'b0};
            bit_cnt   <= bit_cnt + 6'd1;
            if ((bit_cnt + 6'd1) == bit_total) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state    <= ST_IDLE;
            stop_end <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_drive_low = drive_low_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_n64_response_tx.sv
// tb/tb_n64_response_tx.sv - directed and randomized frame checks against a waveform model
module tb_n64_response_tx;

  localparam int US      = 4;
  localparam int BIT_CYC = 4 * US;

  logic sample_clk = 1'b0;
  logic reset      = 1'b1;
  int   tests      = 0;
  int   fails      = 0;

  always #5 sample_clk = ~sample_clk;

  n64_response_tx_if bus ();

  n64_response_tx #(.US_TICKS(US)) dut (
    .sample_clk (sample_clk),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic step();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_bytes(input logic [2:0] nb);
    return (nb > 3'd4) ? 4 : int'(nb);
  endfunction

  // Expected line level i cycles into a frame, from the pulse-width rules
  function automatic logic exp_low(input logic [31:0] pl, input int n, input int i);
    int b;
    int c;
    int low_cyc;
    b = i / BIT_CYC;
    c = i % BIT_CYC;
    if (b < 8 * n) low_cyc = pl[31 - b] ? US : 3 * US;
    else           low_cyc = 2 * US;
    return (c < low_cyc);
  endfunction

  task automatic issue(input logic [31:0] pl, input logic [2:0] nb);
    bus.start     = 1'b1;
    bus.num_bytes = nb;
    bus.payload   = pl;
    step();
    bus.start     = 1'b0;
    bus.payload   = $urandom();
    bus.num_bytes = 3'($urandom_range(0, 7));
  endtask

  task automatic watch(input string tag, input logic [31:0] pl, input logic [2:0] nb,
                       input int inject, input bit chain,
                       input logic [31:0] pl2, input logic [2:0] nb2);
    int n;
    int len;
    int wave_err;
    int busy_err;
    int done_err;
    logic e_ddl;
    n        = clamp_bytes(nb);
    len      = (8 * n + 1) * BIT_CYC;
    wave_err = 0;
    busy_err = 0;
    done_err = 0;
    for (int i = 0; i <= len; i++) begin
      step();
      e_ddl = (i < len) ? exp_low(pl, n, i) : 1'b0;
      if (bus.data_drive_low !== e_ddl)   wave_err++;
      if (bus.busy !== (i < len))         busy_err++;
      if (bus.done !== (i == len))        done_err++;
      if (i == inject) begin
        bus.start     = 1'b1;
        bus.payload   = $urandom();
        bus.num_bytes = 3'd4;
      end else if (i == inject + 1) begin
        bus.start = 1'b0;
      end
      if (chain && i == len) begin
        bus.start     = 1'b1;
        bus.payload   = pl2;
        bus.num_bytes = nb2;
      end
    end
    check($sformatf("%s_wave_errs", tag), wave_err, 0);
    check($sformatf("%s_busy_errs", tag), busy_err, 0);
    check($sformatf("%s_done_errs", tag), done_err, 0);
    if (!chain) begin
      step();
      check($sformatf("%s_post_done", tag), {31'd0, bus.done}, 0);
      check($sformatf("%s_post_busy", tag), {31'd0, bus.busy}, 0);
    end
  endtask

  initial begin
    int errs;
    logic [31:0] pl;
    logic [31:0] pl_b;
    logic [2:0]  nb;
    logic [2:0]  nb_b;

    bus.start     = 1'b0;
    bus.num_bytes = 3'd0;
    bus.payload   = 32'd0;

    // Reset held with random activity on the inputs
    reset = 1'b1;
    errs  = 0;
    for (int i = 0; i < 6; i++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.num_bytes = 3'($urandom_range(0, 7));
      bus.payload   = $urandom();
      step();
      if ({bus.data_drive_low, bus.busy, bus.done} !== 3'b000) errs++;
    end
    check("reset_outputs", errs, 0);
    bus.start = 1'b0;
    reset     = 1'b0;
    step();
    check("idle_after_reset", {29'd0, bus.data_drive_low, bus.busy, bus.done}, 0);

    issue(32'h05000200, 3'd3);
    watch("info", 32'h05000200, 3'd3, -10, 1'b0, 32'd0, 3'd0);

    issue(32'h80000001, 3'd4);
    watch("status", 32'h80000001, 3'd4, -10, 1'b0, 32'd0, 3'd0);

    pl = $urandom();
    issue(pl, 3'd4);
    watch("ignore_mid", pl, 3'd4, 50, 1'b0, 32'd0, 3'd0);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
    end
    check("no_extra_frame", errs, 0);

    bus.start     = 1'b1;
    bus.num_bytes = 3'd0;
    bus.payload   = $urandom();
    step();
    bus.start = 1'b0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy !== 1'b0) errs++;
    end
    check("zero_bytes_ignored", errs, 0);

    issue(32'h80000001, 3'd7);
    watch("clamp7", 32'h80000001, 3'd7, -10, 1'b0, 32'd0, 3'd0);

    // Abort in the low slot of bit 10
    pl = $urandom();
    issue(pl, 3'd4);
    for (int i = 0; i <= 10 * BIT_CYC + 1; i++) step();
    check("abort_pre_low", {31'd0, bus.data_drive_low}, 1);
    reset = 1'b1;
    step();
    check("abort_release", {29'd0, bus.data_drive_low, bus.busy, bus.done}, 0);
    step();
    step();
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) errs++;
    end
    check("abort_no_done", errs, 0);
    issue(32'h05000200, 3'd3);
    watch("post_abort", 32'h05000200, 3'd3, -10, 1'b0, 32'd0, 3'd0);

    // Second frame requested in the done cycle of the first
    pl   = $urandom();
    nb   = 3'($urandom_range(1, 4));
    pl_b = $urandom();
    nb_b = 3'($urandom_range(1, 4));
    issue(pl, nb);
    watch("b2b_first", pl, nb, -10, 1'b1, pl_b, nb_b);
    step();
    bus.start     = 1'b0;
    bus.payload   = $urandom();
    bus.num_bytes = 3'($urandom_range(0, 7));
    watch("b2b_second", pl_b, nb_b, -10, 1'b0, 32'd0, 3'd0);

    for (int k = 0; k < 4; k++) begin
      pl = $urandom();
      nb = 3'($urandom_range(1, 7));
      issue(pl, nb);
      watch($sformatf("rand%0d", k), pl, nb, -10, 1'b0, 32'd0, 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n64_response_tx.md
# n64_response_tx

Transmit half of the fake N64 controller. It serializes a controller response (1–4 bytes, MSB first) onto the N64 single-wire data line using the N64 pulse-width bit encoding, and appends the controller stop bit. It sits beside the command receiver in the fake controller top level: the receiver decodes the console command, and the controller logic then loads the response payload here and pulses `start`. The top level drives the open-drain pad from `data_drive_low`.

## Interface
- `US_TICKS`, default 4: `sample_clk` cycles per 1 µs slot; must be ≥ 2.
- `sample_clk`  input  1  Sole clock; all logic updates on the rising edge.
- `reset`  input  1  Synchronous, active-high reset.
- `start`  input  1  Request to transmit; sampled only in IDLE.
- `num_bytes`  input  3  Response length in bytes; sampled with `start`.
- `payload`  input  32  Response data, left-justified; the first bit sent is `payload[31]`. Sampled with `start`.
- `data_drive_low`  output  1  1 = pull the line low; 0 = release it (pulled high externally).
- `busy`  output  1  High while a frame is in progress.
- `done`  output  1  One-cycle pulse at the end of a frame.

## Operation
- Reset values: `data_drive_low`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.
- States:
  - IDLE: line released.
  - DATA: sending payload bits.
  - STOP: sending the stop bit.
  - The frame returns to IDLE after the STOP state completes.
- Accept rule: in IDLE, `start`=1 with `num_bytes`≠0 latches `payload` into a 32-bit shift register and sets bit total = 8×min(`num_bytes`,4). State then moves to DATA.
- Ignored starts:
  - `num_bytes`=0 is ignored; the block stays in IDLE.
  - Values 5–7 are clamped to 4.
  - `start` while `busy` is ignored. The latched payload is unaffected by later input changes.
- Each bit is 4 slots of `US_TICKS` cycles each; slot index runs 0..3.
  - Bit '1': low in slot 0, released in slots 1–3.
  - Bit '0': low in slots 0–2, released in slot 3.
  - Stop bit: low in slots 0–1, released in slots 2–3.
- After slot 3 of a bit:
  - Shift left by one and increment the bit count.
  - If bit count = bit total, go to STOP; otherwise start the next bit.
- After slot 3 of STOP: go to IDLE and pulse `done`.
- Counters:
  - Tick counter: 0..`US_TICKS`-1, wraps to 0 and advances the slot.
  - Slot counter: 2 bits, wraps 3→0 and advances the bit.
  - Bit counter: 6 bits.
  - No overflow is possible because bit total ≤ 32.
- `data_drive_low` is registered and is a function of the current state, slot and shift-register MSB only.
- Reset during a frame takes priority over everything. The next edge gives line released, `busy`=0, `done` never pulses for the aborted frame, and the state is IDLE. A new `start` is accepted the cycle after `reset` deasserts.

## Timing
- Start latency: if `start` is sampled at edge k, then `busy`=1 and the first low slot of bit 0 are both visible after edge k+1.
- Bit time: 4×`US_TICKS` cycles. Frame length: (8N+1)×4×`US_TICKS` cycles with `busy`=1, where N is the clamped byte count.
- End of frame: `done`=1 for exactly one cycle, namely the first cycle with `busy`=0. The line is released in that cycle.
- Back-to-back frames: `start` may be asserted during the `done` cycle and is accepted, because that cycle is in IDLE. No mandatory gap beyond this is required.
- Timing accuracy: exact integer multiples of the `sample_clk` period. Jitter is 0 cycles.

## Structure
- Shared package `n64_pkg` holds:
  - The state encoding localparams (IDLE, DATA, STOP) and the 2-bit slot width.
  - Command codes: INFO 8'h00, STATUS 8'h01, READ 8'h02, WRITE 8'h03, RESET 8'hFF.
  - Response lengths: INFO 3 bytes, STATUS 4 bytes.
  - The slot patterns (low-slot counts: '1'=1, '0'=3, stop=2).
- One sub-module, `n64_slot_timer`, is natural.
  - Parameter `US_TICKS`; inputs `sample_clk`, `reset`, `run`.
  - Outputs `slot` (2 bits) and `bit_end` (pulse at the end of slot 3).
  - The state machine and shift register stay in `n64_response_tx`.

## Test plan
All scenarios use `US_TICKS`=4, so one bit = 16 cycles.
- Reset:
  - Stimulus: assert `reset` with random inputs.
  - Response: `data_drive_low`/`busy`/`done` are 0 on the next edge and stay 0 while `reset`=1.
- INFO response:
  - Stimulus: `payload`=32'h05000200, `num_bytes`=3, one-cycle `start`.
  - Bit patterns: '0' bits are low 12 cycles then high 4; '1' bits are low 4 then high 12.
  - Bit stream: 0000_0101 0000_0000 0000_0010.
  - Stop bit: low 8 then high 8.
  - Framing: `busy` for 400 cycles, then `done` pulses once.
- STATUS response:
  - Stimulus: `payload`=32'h80000001, `num_bytes`=4.
  - First bit is low 4 cycles; bits 1–30 are low 12 cycles each; bit 31 is low 4 cycles.
  - Stop bit follows; `busy` lasts 528 cycles.
- Ignore rules:
  - Stimulus: `start` with new `payload` at cycle 50 of an active frame.
  - Response: the waveform is unchanged and there is no extra frame.
  - Stimulus: `num_bytes`=0 with `start`.
  - Response: `busy` stays 0.
  - Stimulus: `num_bytes`=7.
  - Response: same waveform and 528-cycle length as `num_bytes`=4.
- Abort:
  - Stimulus: `reset` asserted during bit 10 while the line is low.
  - Response: the line is released next cycle and no `done` pulses.
  - Follow-up: a new INFO frame started after reset is bit-exact.
- Back-to-back:
  - Stimulus: `start` asserted in the `done` cycle.
  - Response: the second frame's first low slot begins on the following cycle.
